mod7_check_serializer: RTL and testbench
========================================

# mod7_check_serializer

Serial transmitter for the MSB-first divisible-by-7 bit-stream link. It accepts a parallel DATA_W-bit word over a valid/ready handshake and shifts it out MSB first on `string_out`. It then appends a 3-bit check suffix that makes the whole (DATA_W+3)-bit frame an integer divisible by 7. A mod-7 stream checker at the far end therefore sees remainder 0 / divisible on the final bit of every frame.

## Interface
- `DATA_W`, default 8: payload width in bits; legal range 1..32.
- `clock`  in  1  rising-edge clock.
- `Reset`  in  1  reset; synchronous, active-high.
- `data_in`  in  DATA_W  payload word; sampled on handshake.
- `load_valid`  in  1  payload word available.
- `load_ready`  out  1  block can accept a word this cycle.
- `string_out`  out  1  serial bit, MSB first.
- `bit_valid`  out  1  `string_out` carries a frame bit this cycle.
- `frame_last`  out  1  current bit is the last check bit.
- `busy`  out  1  frame in progress.
- `Remainder`  out  3  running value mod 7 of all frame bits up to and including the current `string_out`.

## Operation
- The state machine has three states:
  - IDLE: no frame in progress.
  - DATA: shifts the payload, count runs DATA_W-1..0.
  - CHECK: shifts the check bits, count runs 2..0.
- Handshake:
  - A word is accepted when `load_valid && load_ready` at a rising edge.
  - `load_ready` = !Reset && (state==IDLE || (state==CHECK && count==0)). It is combinational from state.
- On accept:
  - Latch `data_in` into the shift register.
  - Set the running remainder r to 0 and go to DATA.
- DATA: each cycle the block
  - emits shift[DATA_W-1];
  - sets r ← (2r + bit) mod 7;
  - shifts left.
  - After the DATA_W-th bit it computes c = (7 − r) mod 7 and goes to CHECK.
  - Because 8 ≡ 1 (mod 7), c ≡ −payload (mod 7).
- CHECK:
  - Emits c[2], c[1], c[0] in order and keeps updating r the same way. r is 0 after c[0].
  - On the last check bit, `frame_last`=1.
  - The next state is DATA if a word is accepted that cycle (gapless back-to-back frames); otherwise IDLE.
- Outputs:
  - `string_out`, `bit_valid`, `frame_last`, `busy` and `Remainder` are registered.
  - `Remainder` is the post-update r for the bit currently on `string_out`.
  - `bit_valid` = `busy` = 1 on every frame bit.
  - In IDLE, `string_out`=0, `bit_valid`=0, `frame_last`=0, `busy`=0 and `Remainder`=0.
- Remainder arithmetic: 2r+b is at most 13, computed in 4 bits. Subtract 7 if the sum is ≥ 7; the result is always in 0..6.
- `load_valid` while `load_ready`=0 is ignored. `data_in` is not held or queued.

## Timing
- Reset:
  - While `Reset`=1, all outputs are 0, including `load_ready`, and the state is IDLE.
  - Reset mid-frame aborts the frame at the next edge; no further bits of that frame are emitted.
- Latency: with the accept edge at cycle T,
  - payload bits appear in cycles T+1..T+DATA_W;
  - check bits appear in cycles T+DATA_W+1..T+DATA_W+3;
  - `frame_last` is asserted at T+DATA_W+3.
- Throughput: back-to-back accept in the `frame_last` cycle gives one frame every DATA_W+3 cycles with no idle gap.
- Simultaneous `Reset` and `load_valid`: `Reset` wins; the word is not accepted.

## Structure
- Shared package `mod7_pkg` holds:
  - the state encoding (IDLE/DATA/CHECK);
  - the constant `MOD7 = 3'd7`;
  - the function `mod7_step(r, b)` returning (2r+b) mod 7.
  - The stream checker reuses the same function.
- One natural sub-module: `mod7_step_unit`, a combinational 3-bit remainder update. It is shared by the payload and check phases.
- Counter width is $clog2(DATA_W).

## Test plan
- DATA_W=8, `data_in`=0x0A accepted → `string_out` = 0000_1010 then 100 (c=4); `Remainder` ends 0 with `frame_last`=1 on bit 11.
- `data_in`=0x0D → check bits 001; frame value 105; `Remainder` sequence 0,0,0,0,1,3,6,6,5,3,0.
- `data_in`=0x00 and 0x07 → check bits 000; `Remainder`=0 on the last bit.
- Two words 0xFF then 0x0A, with `load_valid` held continuously → second accept occurs in the first frame's `frame_last` cycle, `bit_valid` stays 1 for 22 cycles, check suffixes are 100 and 100.
- `Reset` pulsed at payload bit 4 → next cycle all outputs 0 and `load_ready`=1 after release; a new word 0x0D yields the correct full frame.
- `load_valid` asserted mid-frame → ignored (`load_ready`=0); the frame completes unchanged.

Source files
------------

// File: rtl/mod7_pkg.sv
// Shared definitions for the MSB-first divisible-by-7 serial link:
// state encoding, modulus constant and the remainder update rule.
package mod7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } mod7_state_t;

  localparam logic [2:0] MOD7 = 3'd7;

  // (2r + b) mod 7; 2r+b never exceeds 13, so one conditional subtract suffices.
  function automatic logic [2:0] mod7_step(input logic [2:0] r, input logic b);
    logic [3:0] s;
    s = {r, 1'b0} + {3'b000, b};
    if (s >= {1'b0, MOD7})
      s = s - {1'b0, MOD7};
    return s[2:0];
  endfunction

  // Suffix c that drives the running remainder to zero: (7 - r) mod 7.
  function automatic logic [2:0] mod7_suffix(input logic [2:0] r);
    return (r == 3'd0) ? 3'd0 : (MOD7 - r);
  endfunction

endpackage

// File: rtl/mod7_check_serializer_step_unit.sv
// Combinational 3-bit remainder update shared by payload and check phases.
module mod7_step_unit
  import mod7_pkg::*;
(
  input  logic [2:0] r,
  input  logic       b,
  output logic [2:0] r_next
);

  assign r_next = mod7_step(r, b);

endmodule

// File: rtl/mod7_check_serializer.sv
// Serialises a DATA_W-bit word MSB first and appends a 3-bit suffix that
// makes every frame an integer divisible by 7.
module mod7_check_serializer
  import mod7_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              string_out,
  output logic              bit_valid,
  output logic              frame_last,
  output logic              busy,
  output logic [2:0]        Remainder
);

  // The counter also walks the 2..0 check phase, so it is never narrower than 2 bits.
  localparam int unsigned CW = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);

  mod7_state_t       state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [CW-1:0]     count, count_n;
  logic [2:0]        chk, chk_n;
  logic [2:0]        rem, rem_n;
  logic              sout, sout_n;
  logic              last, last_n;
  logic              valid, valid_n;

  logic              accept;
  logic [2:0]        suffix;
  logic [2:0]        r_in;
  logic              b_in;
  logic [2:0]        r_out;

  assign load_ready = !Reset && ((state == ST_IDLE) ||
                                 ((state == ST_CHECK) && (count == '0)));
  assign accept     = load_valid && load_ready;
  assign suffix     = mod7_suffix(rem);

  // Selects the bit that goes out next; an accept restarts the remainder at 0.
  always_comb begin
    r_in = rem;
    b_in = 1'b0;
    if (accept) begin
      r_in = '0;
      b_in = data_in[DATA_W-1];
    end else begin
      case (state)
        ST_DATA:  b_in = (count == '0) ? suffix[2] : shift[DATA_W-1];
        ST_CHECK: b_in = chk[2];
        default:  b_in = 1'b0;
      endcase
    end
  end

  mod7_step_unit u_step (
    .r      (r_in),
    .b      (b_in),
    .r_next (r_out)
  );

  // Registers describe the bit on string_out, so the transition out of each
  // state is also where the next bit is produced.
  always_comb begin
    state_n = state;
    shift_n = shift;
    count_n = count;
    chk_n   = chk;
    rem_n   = '0;
    sout_n  = 1'b0;
    last_n  = 1'b0;

    case (state)
      ST_DATA: begin
        sout_n = b_in;
        rem_n  = r_out;
        if (count != '0) begin
          shift_n = shift << 1;
          count_n = count - CW'(1);
        end else begin
          chk_n   = {suffix[1:0], 1'b0};
          count_n = CW'(2);
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (count != '0) begin
          sout_n  = b_in;
          rem_n   = r_out;
          chk_n   = chk << 1;
          count_n = count - CW'(1);
          last_n  = (count == CW'(1));
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (accept) begin
      sout_n  = b_in;
      rem_n   = r_out;
      shift_n = data_in << 1;
      count_n = CW'(DATA_W - 1);
      last_n  = 1'b0;
      state_n = ST_DATA;
    end

    valid_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      shift <= '0;
      count <= '0;
      chk   <= '0;
      rem   <= '0;
      sout  <= 1'b0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      count <= count_n;
      chk   <= chk_n;
      rem   <= rem_n;
      sout  <= sout_n;
      last  <= last_n;
      valid <= valid_n;
    end
  end

  assign string_out = sout;
  assign frame_last = last;
  assign bit_valid  = valid;
  assign busy       = valid;
  assign Remainder  = rem;

endmodule

// File: tb/tb_mod7_check_serializer.sv
// Scoreboard bench: accepted words expand into expected frame bits computed
// arithmetically from the frame value; a negedge monitor compares each cycle.
module tb_mod7_check_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned FL = DW + 3;

  logic          clock = 1'b0;
  logic          Reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          load_ready;
  logic          string_out;
  logic          bit_valid;
  logic          frame_last;
  logic          busy;
  logic [2:0]    Remainder;

  mod7_check_serializer #(.DATA_W(DW)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .string_out (string_out),
    .bit_valid  (bit_valid),
    .frame_last (frame_last),
    .busy       (busy),
    .Remainder  (Remainder)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       b;
    logic [2:0] rem;
    logic       last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned acc_cnt = 0;
  logic        exp_ready = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame value = payload*8 + c, with c chosen so the frame is a multiple of 7;
  // the remainder after bit i is simply the frame's leading (i+1) bits mod 7.
  task automatic push_frame(input logic [DW-1:0] w);
    longint unsigned wv, c, frame, pre;
    exp_t e;
    wv    = longint'(w);
    c     = (7 - (wv % 7)) % 7;
    frame = wv * 8 + c;
    for (int i = 0; i < int'(FL); i++) begin
      pre    = frame >> (FL - 1 - i);
      e.b    = pre[0];
      e.rem  = 3'(pre % 7);
      e.last = (i == int'(FL) - 1);
      q.push_back(e);
    end
  endtask

  always @(posedge clock) begin
    if (Reset) begin
      q.delete();
    end else if (load_valid && exp_ready) begin
      push_frame(data_in);
      acc_cnt++;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    if (q.size() > 0) begin
      e    = q.pop_front();
      have = 1'b1;
      check("bit_valid",  int'(bit_valid),  1);
      check("busy",       int'(busy),       1);
      check("string_out", int'(string_out), int'(e.b));
      check("Remainder",  int'(Remainder),  int'(e.rem));
      check("frame_last", int'(frame_last), int'(e.last));
    end else begin
      check("idle_bit_valid",  int'(bit_valid),  0);
      check("idle_busy",       int'(busy),       0);
      check("idle_string_out", int'(string_out), 0);
      check("idle_Remainder",  int'(Remainder),  0);
      check("idle_frame_last", int'(frame_last), 0);
    end
    exp_ready = !Reset && (!have || e.last);
    check("load_ready", int'(load_ready), int'(exp_ready));
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Holds load_valid until the word is taken; load_valid stays high afterwards.
  task automatic send(input logic [DW-1:0] w);
    int unsigned start;
    int n;
    start      = acc_cnt;
    load_valid = 1'b1;
    data_in    = w;
    n = 0;
    while (acc_cnt == start && n < 100) begin
      tick();
      n++;
    end
    if (acc_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 expected=1 word=%0h", w);
    end
  endtask

  task automatic drop_valid();
    load_valid = 1'b0;
    data_in    = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", q.size());
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    Reset = 1'b0;
    tick();

    send(8'h0A); drop_valid(); wait_idle();
    send(8'h0D); drop_valid(); wait_idle();
    send(8'h00); drop_valid(); wait_idle();
    send(8'h07); drop_valid(); wait_idle();

    send(8'hFF); send(8'h0A); drop_valid(); wait_idle();

    send(8'h0A); drop_valid();
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    send(8'h0D); drop_valid(); wait_idle();

    send(8'h0A); drop_valid();
    repeat (3) tick();
    load_valid = 1'b1;
    data_in    = 8'h55;
    repeat (3) tick();
    drop_valid();
    wait_idle();

    Reset      = 1'b1;
    load_valid = 1'b1;
    data_in    = 8'h33;
    tick();
    Reset = 1'b0;
    drop_valid();
    tick();
    wait_idle();

    for (int k = 0; k < 300; k++) begin
      send(DW'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        drop_valid();
        repeat ($urandom_range(0, 4)) tick();
      end
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 10)) tick();
        Reset      = 1'b1;
        load_valid = 1'($urandom_range(0, 1));
        tick();
        Reset = 1'b0;
        drop_valid();
      end
    end
    drop_valid();
    wait_idle();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
